// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and default parameters for the PC sequencer.
//   seqState_t   run-controller state encoding (IDLE, LOAD, RUN, HALT)
//   HALT_INSTR   instruction encoding that ends a program
//   *_DEF        default widths for PC, branch offset and retired counter
//   CNT_SAT_DEF  saturation value of the retired counter at its default width
package pc_seq_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int OFF_W_DEF = 6;
  localparam int CNT_W_DEF = 16;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } seqState_t;

endpackage

// File: rtl/pc_sequencer_branch_target.sv
// branch_target: combinational branch-target computation for the PC sequencer.
// Build option: PC_SEQ_BRANCH_ABS_EN
//   defined   -> target is the zero-extended offset (absolute, low 2^OFF_W addresses)
//   undefined -> target is PC + sign-extended offset, wrapping modulo 2^PC_W
// Ports:
//   pc      in   PC_W   current program counter
//   offset  in   OFF_W  branch offset field from the instruction
//   target  out  PC_W   branch destination address
module branch_target #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 6
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  target
);

`ifdef PC_SEQ_BRANCH_ABS_EN
  logic unusedPc;
  assign unusedPc = ^pc;
  assign target   = PC_W'(offset);
`else
  logic [PC_W-1:0] offsetExt;
  // Casting the signed offset keeps its sign while widening to PC_W.
  assign offsetExt = PC_W'($signed(offset));
  assign target    = pc + offsetExt;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run controller for the 9-bit-instruction core.
// Holds the PC presented to the instruction ROM, loads the start address, applies
// taken branches, stops on the halt instruction and counts retired instructions.
// Build option: PC_SEQ_BRANCH_ABS_EN selects absolute branch targets (see branch_target).
// Ports:
//   CLK         in   1      core clock, rising edge
//   Reset       in   1      synchronous active-high reset
//   Start       in   1      level request to (re)load StartAddr and run
//   StartAddr   in   PC_W   first instruction address
//   Instr       in   9      instruction at PC (combinational ROM read)
//   Branch      in   1      decoded branch instruction
//   Zero        in   1      ALU zero flag; branch taken when Branch && Zero
//   Offset      in   OFF_W  branch offset field
//   PC          out  PC_W   instruction address to ROM
//   Running     out  1      high exactly while in RUN
//   Done        out  1      high from halt until next Start or Reset
//   InstrCount  out  CNT_W  retired instructions, saturating
//
// state | meaning
// IDLE  | after reset; PC holds, waits for Start
// LOAD  | Start held: PC <= StartAddr, count cleared; leaves for RUN when Start drops
// RUN   | one instruction retires per cycle
// HALT  | halt retired; PC, count and Done hold until Start
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic [8:0]       Instr,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [OFF_W-1:0] Offset,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seqState_t       state;
  logic [PC_W-1:0] branchPc;

  branch_target #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) uBranchTarget (
    .pc     (PC),
    .offset (Offset),
    .target (branchPc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) state <= LOAD;
        end
        LOAD: begin
          if (Start) begin
            PC         <= StartAddr;
            InstrCount <= '0;
          end else begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (Start) begin
            // Abort: nothing retires on this edge, the reload happens in LOAD.
            state   <= LOAD;
            Running <= 1'b0;
          end else begin
            if (InstrCount != CNT_MAX) InstrCount <= InstrCount + 1'b1;
            if (Instr == HALT_INSTR) begin
              state   <= HALT;
              Running <= 1'b0;
              Done    <= 1'b1;
            end else if (Branch && Zero) begin
              PC <= branchPc;
            end else begin
              PC <= PC + 1'b1;
            end
          end
        end
        HALT: begin
          if (Start) begin
            state <= LOAD;
            Done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int TB_CNT_MAX = 15;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] StartAddr;
  logic [8:0] Instr;
  logic       Branch;
  logic       Zero;
  logic [5:0] Offset;
  logic [7:0] PC;
  logic       Running;
  logic       Done;
  logic [3:0] InstrCount;

  logic [8:0] rom [256];

  assign Instr  = rom[PC];
  assign Offset = Instr[5:0];
  assign Branch = (Instr[8:6] == 3'b101);

  always #5 CLK = ~CLK;

  pc_sequencer #(.PC_W(8), .OFF_W(6), .CNT_W(4)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Instr      (Instr),
    .Branch     (Branch),
    .Zero       (Zero),
    .Offset     (Offset),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .InstrCount (InstrCount)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       run;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: program phase flags plus PC/count as plain integers.
  int mPc = 0, mCnt = 0;
  bit mLoad = 0, mRun = 0, mDone = 0;

  function automatic int targetOf(int pc, int off);
`ifdef PC_SEQ_BRANCH_ABS_EN
    return off;
`else
    int s;
    s = (off >= 32) ? off - 64 : off;
    return (pc + s + 256) % 256;
`endif
  endfunction

  task automatic step();
    exp_t e;
    int ins;
    if (Reset) begin
      mPc = 0; mCnt = 0; mLoad = 0; mRun = 0; mDone = 0;
    end else if (Start) begin
      if (mLoad) begin
        mPc  = int'(StartAddr);
        mCnt = 0;
      end else begin
        mLoad = 1; mRun = 0; mDone = 0;
      end
    end else if (mLoad) begin
      mLoad = 0; mRun = 1;
    end else if (mRun) begin
      ins  = int'(rom[mPc]);
      mCnt = (mCnt < TB_CNT_MAX) ? mCnt + 1 : TB_CNT_MAX;
      if (ins == 'h1FF) begin
        mRun = 0; mDone = 1;
      end else if ((ins >> 6) == 5 && Zero) begin
        mPc = targetOf(mPc, ins % 64);
      end else begin
        mPc = (mPc + 1) % 256;
      end
    end
    e.pc = 8'(mPc); e.run = mRun; e.done = mDone; e.cnt = 4'(mCnt);
    expQ.push_back(e);
    @(negedge CLK);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nCompared++;
        if ({PC, Running, Done, InstrCount} !== e) begin
          nMismatched++;
          $display("FAIL cycle_check t=%0t: got PC=%h Running=%b Done=%b InstrCount=%0d, want PC=%h Running=%b Done=%b InstrCount=%0d",
                   $time, PC, Running, Done, InstrCount, e.pc, e.run, e.done, e.cnt);
        end
      end
    end
  end

  task automatic expectNow(string name, int pc, bit run, bit done, int cnt);
    nCompared++;
    if (PC !== 8'(pc) || Running !== run || Done !== done || InstrCount !== 4'(cnt)) begin
      nMismatched++;
      $display("FAIL %s: got PC=%h Running=%b Done=%b InstrCount=%0d, want PC=%h Running=%b Done=%b InstrCount=%0d",
               name, PC, Running, Done, InstrCount, 8'(pc), run, done, cnt);
    end
  endtask

  task automatic runFrom(int addr);
    StartAddr = 8'(addr);
    Start = 1; step(); step();
    Start = 0; step();
  endtask

  initial begin : stimulus
    int startLeft;
    int x;
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    Reset = 1; Start = 0; Zero = 0; StartAddr = 8'h00;
    step(); step();
    Reset = 0; step();
    expectNow("reset_state", 0, 0, 0, 0);

    // Reset in the middle of a program.
    runFrom('h32);
    repeat (5) step();
    expectNow("pre_reset_run", 'h37, 1, 0, 5);
    Reset = 1; step(); Reset = 0;
    expectNow("reset_mid_run", 0, 0, 0, 0);
    step();
    expectNow("idle_hold", 0, 0, 0, 0);

    // Four plain instructions then halt at 0x14.
    rom['h14] = 9'h1FF;
    StartAddr = 8'h10; Start = 1;
    repeat (3) step();
    Start = 0; step();
    expectNow("run_entry", 'h10, 1, 0, 0);
    repeat (5) step();
    expectNow("halt_reached", 'h14, 0, 1, 5);
    step(); step();
    expectNow("halt_hold", 'h14, 0, 1, 5);

    // Restart from HALT.
    StartAddr = 8'h40; Start = 1; step();
    expectNow("abort_done_clear", 'h14, 0, 0, 5);
    step();
    expectNow("reload", 'h40, 0, 0, 0);
    Start = 0; step();
    expectNow("resume", 'h40, 1, 0, 0);
    step();
    expectNow("resume_inc", 'h41, 1, 0, 1);
    rom['h14] = 9'h000;

    // Taken and not-taken branch at 0x20, offset 0x3C.
    rom['h20] = {3'b101, 6'h3C};
    Zero = 1; runFrom('h20); step();
`ifdef PC_SEQ_BRANCH_ABS_EN
    expectNow("branch_taken", 'h3C, 1, 0, 1);
`else
    expectNow("branch_taken", 'h1C, 1, 0, 1);
`endif
    Zero = 0; runFrom('h20); step();
    expectNow("branch_not_taken", 'h21, 1, 0, 1);

    // PC wrap and a backward branch across zero.
    runFrom('hFF); step();
    expectNow("pc_wrap", 'h00, 1, 0, 1);
    rom['h02] = {3'b101, 6'h3D};
    Zero = 1; runFrom('h02); step();
`ifdef PC_SEQ_BRANCH_ABS_EN
    expectNow("branch_neg_wrap", 'h3D, 1, 0, 1);
`else
    expectNow("branch_neg_wrap", 'hFF, 1, 0, 1);
`endif

    // Self-loop for 20 cycles: counter saturates at 15.
    rom['h50] = {3'b101, 6'h00};
    runFrom('h50);
    repeat (20) step();
    expectNow("count_saturate", 'h50, 1, 0, 15);
    Reset = 1; step(); Reset = 0;

    // Randomized program contents, flags, starts and resets.
    for (int i = 0; i < 256; i++) begin
      x = int'($urandom_range(0, 15));
      if (x < 2) rom[i] = 9'h1FF;
      else if (x < 6) rom[i] = {3'b101, 6'($urandom)};
      else begin
        rom[i] = 9'($urandom);
        if (rom[i][8:6] == 3'b101) rom[i][8] = 1'b0;
        if (rom[i] == 9'h1FF) rom[i] = 9'h000;
      end
    end
    startLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      Zero = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1; Start = 0; startLeft = 0;
      end else begin
        Reset = 0;
        if (startLeft == 0 &&
            ($urandom_range(0, 39) == 0 || (!mRun && !mLoad && $urandom_range(0, 3) == 0))) begin
          startLeft = int'($urandom_range(2, 4));
          StartAddr = 8'($urandom);
        end
        if (startLeft > 0) begin
          Start = 1; startLeft--;
        end else begin
          Start = 0;
        end
      end
      step();
    end

    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
